// File: rtl/cnt_arb_pkg.sv
// Shared types and defaults for the cnt_arb round-robin interval scheduler.
package cnt_arb_pkg;

  localparam int unsigned CNT_ARB_N_REQ = 4;
  localparam int unsigned CNT_ARB_CW    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set req bit after pointer, with wrap.
module rr_pick
  import cnt_arb_pkg::*;
#(
  parameter int unsigned N_REQ = CNT_ARB_N_REQ
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] pointer,
  output logic                     valid,
  output logic [$clog2(N_REQ)-1:0] owner
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0] w_idx;

  // Candidates are visited nearest-first, so the first hit is the winner.
  always_comb begin
    valid = 1'b0;
    owner = '0;
    w_idx = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      w_idx = PTR_W'((32'(pointer) + k) % N_REQ);
      if (!valid && req[w_idx]) begin
        valid = 1'b1;
        owner = w_idx;
      end
    end
  end

endmodule

// File: rtl/cnt_arb.sv
// Round-robin scheduler sharing one interval counter among N_REQ requesters.
// Optional CNT_ARB_HOLD_EN adds a hold input that freezes the running window.
module cnt_arb
  import cnt_arb_pkg::*;
#(
  parameter int unsigned N_REQ = CNT_ARB_N_REQ,
  parameter int unsigned CW    = CNT_ARB_CW
) (
  input  logic              clk,
  input  logic              reset,
`ifdef CNT_ARB_HOLD_EN
  input  logic              hold,
`endif
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*CW-1:0] len,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    done,
  output logic                busy,
  output logic [CW-1:0]       count
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  state_t           r_state;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] r_owner;
  logic [CW-1:0]    r_len_q;
  logic [CW-1:0]    r_count;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] r_done;
  logic             r_busy;

  logic             w_valid;
  logic [PTR_W-1:0] w_win;
  logic [CW-1:0]    w_len_win;
  logic [N_REQ-1:0] w_win_oh;
  logic             w_last;
  logic             w_hold;

`ifdef CNT_ARB_HOLD_EN
  assign w_hold = hold;
`else
  assign w_hold = 1'b0;
`endif

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req     (req),
    .pointer (r_ptr),
    .valid   (w_valid),
    .owner   (w_win)
  );

  assign w_len_win = len[32'(w_win) * CW +: CW];
  assign w_win_oh  = N_REQ'(1) << w_win;
  assign w_last    = (r_count == r_len_q - CW'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= PTR_W'(N_REQ - 1);
      r_owner <= '0;
      r_len_q <= '0;
      r_count <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_owner <= w_win;
            r_len_q <= w_len_win;
            r_count <= '0;
            r_busy  <= 1'b1;
            if (w_len_win != '0) begin
              r_state <= ST_RUN;
              r_gnt   <= w_win_oh;
            end else begin
              r_state <= ST_DONE;
              r_done  <= w_win_oh;
            end
          end
        end
        ST_RUN: begin
          // Completion wins over a same-cycle req drop; hold defers completion.
          if (!w_hold && w_last) begin
            r_state <= ST_DONE;
            r_gnt   <= '0;
            r_count <= '0;
            r_done  <= r_gnt;
          end else if (!req[r_owner]) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= r_owner;
          end else if (!w_hold) begin
            r_count <= r_count + CW'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_ptr   <= r_owner;
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
          r_count <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt   = r_gnt;
  assign done  = r_done;
  assign busy  = r_busy;
  assign count = r_count;

endmodule
